// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: PC register hook-up, instruction-memory
// req/gnt + rvalid port, redirect input and the decode-side handshake.
// The master modport is the fetch queue; the slave modport is its environment.
interface fetch_queue_if #(
    parameter int CNT_W = 3
);
    logic [29:0]      pc;
    logic             pc_en;
    logic             imem_req;
    logic [29:0]      imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [31:0]      imem_rdata;
    logic             flush;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_instr;
    logic [29:0]      id_pc;
    logic [CNT_W-1:0] count;

    modport master (
        input  pc, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
        output pc_en, imem_req, imem_addr, id_valid, id_instr, id_pc, count
    );

    modport slave (
        output pc, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
        input  pc_en, imem_req, imem_addr, id_valid, id_instr, id_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one imem request at a time from the current
// PC, buffers {instr, pc} pairs in a DEPTH-entry FIFO and hands the head to
// decode. Drives the PC register enable so the PC only moves on a grant or a
// redirect.
// Optional feature macro: FETCH_BYPASS_EN -- lets a response reach decode in
// the same cycle it arrives when the FIFO is empty.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]       state, state_nx;
    logic [29:0]      req_pc;
    logic [31:0]      mem_instr [DEPTH];
    logic [29:0]      mem_pc    [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             rsp_ok, push, pop, nempty;

    // A response is usable only while a request is really outstanding and
    // no redirect is killing it.
    assign rsp_ok = (state == WAIT) && bus.imem_rvalid && !bus.flush;
    assign nempty = (cnt != '0);
    // Popping during a flush is pointless: the FIFO is being cleared anyway.
    assign pop    = nempty && bus.id_ready && !bus.flush;

`ifdef FETCH_BYPASS_EN
    logic byp;
    // Empty FIFO: show the arriving response directly to decode.
    assign byp          = rsp_ok && !nempty;
    assign push         = rsp_ok && !(byp && bus.id_ready);
    assign bus.id_valid = nempty || byp;
    assign bus.id_instr = byp ? bus.imem_rdata : mem_instr[rd_ptr];
    assign bus.id_pc    = byp ? req_pc         : mem_pc[rd_ptr];
`else
    assign push         = rsp_ok;
    assign bus.id_valid = nempty;
    assign bus.id_instr = mem_instr[rd_ptr];
    assign bus.id_pc    = mem_pc[rd_ptr];
`endif

    // The request address is the live PC; it stays put because pc_en is low
    // until the grant.
    assign bus.imem_req  = (state == REQ);
    assign bus.imem_addr = bus.pc;
    assign bus.pc_en     = bus.flush || ((state == REQ) && bus.imem_gnt);
    assign bus.count     = cnt;

    // Occupancy after this cycle's push/pop; flush empties the queue.
    always_comb begin
        cnt_nx = cnt;
        if (bus.flush) begin
            cnt_nx = '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_nx = cnt + 1'b1;
                2'b01:   cnt_nx = cnt - 1'b1;
                default: cnt_nx = cnt;
            endcase
        end
    end

    // Request sequencer. Issue only with a free slot so the single
    // outstanding response always has somewhere to land.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if ((cnt < FULL) && !bus.flush) state_nx = REQ;
            end
            REQ: begin
                if (bus.imem_gnt)        state_nx = bus.flush ? DRAIN : WAIT;
                else if (bus.flush)      state_nx = IDLE;
            end
            WAIT: begin
                if (bus.flush)            state_nx = bus.imem_rvalid ? IDLE : DRAIN;
                else if (bus.imem_rvalid) state_nx = (cnt_nx < FULL) ? REQ : IDLE;
            end
            DRAIN: begin
                // The stale response is swallowed here.
                if (bus.imem_rvalid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and the PC latched with the granted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            state <= state_nx;
            if ((state == REQ) && bus.imem_gnt) req_pc <= bus.pc;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two DEPTH).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            cnt <= cnt_nx;
            if (bus.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (push) begin
            mem_instr[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]    <= req_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: PC register model, simple imem responder
// with programmable response delay, and a linear sequence of checked steps.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] redirect;
    int          rsp_delay;
    int          checks   = 0;
    int          failures = 0;
    int          grant_cnt = 0;
    int          g0;
    logic        rsp_pend = 1'b0;
    int          rsp_wait = 0;
    logic [29:0] rsp_addr = '0;
    logic [29:0] exp_pc;

    always #5 clk = ~clk;

    fetch_queue_if #(.CNT_W(3)) bus ();

    fetch_queue #(.DEPTH(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // PC register: sequential next PC, or redirect target on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             bus.pc <= 30'hc00;
        else if (bus.pc_en)  bus.pc <= bus.flush ? redirect : bus.pc + 30'd1;
    end

    // Instruction memory: rdata = byte address of the fetched word.
    always @(posedge clk) begin
        bus.imem_rvalid <= 1'b0;
        if (rsp_pend) begin
            if (rsp_wait <= 1) begin
                bus.imem_rvalid <= 1'b1;
                bus.imem_rdata  <= {rsp_addr, 2'b00};
                rsp_pend        <= 1'b0;
            end else begin
                rsp_wait <= rsp_wait - 1;
            end
        end
        if (!rst && bus.imem_req && bus.imem_gnt) begin
            grant_cnt <= grant_cnt + 1;
            if (rsp_delay == 0) begin
                bus.imem_rvalid <= 1'b1;
                bus.imem_rdata  <= {bus.imem_addr, 2'b00};
            end else begin
                rsp_pend <= 1'b1;
                rsp_addr <= bus.imem_addr;
                rsp_wait <= rsp_delay;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cnt(input logic [2:0] target, input string tag);
        int n;
        n = 0;
        while (bus.count !== target && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 64'(bus.count), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; bus.flush = 1'b0; bus.imem_gnt = 1'b1; bus.id_ready = 1'b1;
        redirect = '0; rsp_delay = 0;
        tick(); tick();

        // Reset values
        chk("rst_req",    64'(bus.imem_req), 64'd0);
        chk("rst_pc_en",  64'(bus.pc_en),    64'd0);
        chk("rst_valid",  64'(bus.id_valid), 64'd0);
        chk("rst_instr",  64'(bus.id_instr), 64'd0);
        chk("rst_id_pc",  64'(bus.id_pc),    64'd0);
        chk("rst_count",  64'(bus.count),    64'd0);

        // Streaming fetch, decode always ready
        rst = 1'b0;
        tick();
        chk("t1_req0",    64'(bus.imem_req),  64'd1);
        chk("t1_addr0",   64'(bus.imem_addr), 64'hc00);
        chk("t1_pcen0",   64'(bus.pc_en),     64'd1);
        tick();
        chk("t1_wait_req",   64'(bus.imem_req), 64'd0);
        chk("t1_wait_pcen",  64'(bus.pc_en),    64'd0);
        chk("t1_wait_valid", 64'(bus.id_valid), 64'd0);
        tick();
        chk("t1_addr1",   64'(bus.imem_addr), 64'hc01);
        chk("t1_pcen1",   64'(bus.pc_en),     64'd1);
        chk("t1_valid0",  64'(bus.id_valid),  64'd1);
        chk("t1_instr0",  64'(bus.id_instr),  64'h3000);
        chk("t1_idpc0",   64'(bus.id_pc),     64'hc00);
        tick();
        chk("t1_popped",  64'(bus.count),     64'd0);
        tick();
        chk("t1_addr2",   64'(bus.imem_addr), 64'hc02);
        chk("t1_instr1",  64'(bus.id_instr),  64'h3004);
        chk("t1_idpc1",   64'(bus.id_pc),     64'hc01);

        // Fill to DEPTH with decode stalled
        rst = 1'b1; bus.id_ready = 1'b0;
        tick(); tick();
        g0 = grant_cnt;
        rst = 1'b0;
        repeat (12) tick();
        chk("t2_full",    64'(bus.count),       64'd4);
        chk("t2_idle",    64'(bus.imem_req),    64'd0);
        chk("t2_grants",  64'(grant_cnt - g0),  64'd4);
        chk("t2_pc",      64'(bus.pc),          64'hc04);
        chk("t2_head",    64'(bus.id_pc),       64'hc00);
        bus.id_ready = 1'b1;
        #1;
        chk("t2_valid",   64'(bus.id_valid),    64'd1);
        tick();
        bus.id_ready = 1'b0;
        chk("t2_cnt3",    64'(bus.count),       64'd3);
        chk("t2_head1",   64'(bus.id_pc),       64'hc01);
        chk("t2_still_idle", 64'(bus.imem_req), 64'd0);
        tick();
        chk("t2_req",     64'(bus.imem_req),    64'd1);
        chk("t2_addr",    64'(bus.imem_addr),   64'hc04);
        tick(); tick();
        chk("t2_refull",  64'(bus.count),       64'd4);
        chk("t2_grants5", 64'(grant_cnt - g0),  64'd5);
        chk("t2_idle2",   64'(bus.imem_req),    64'd0);

        // Grant withheld
        rst = 1'b1; bus.imem_gnt = 1'b0; bus.id_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_req_%0d", i),  64'(bus.imem_req),  64'd1);
            chk($sformatf("t3_addr_%0d", i), 64'(bus.imem_addr), 64'hc00);
            chk($sformatf("t3_pcen_%0d", i), 64'(bus.pc_en),     64'd0);
            tick();
        end
        bus.imem_gnt = 1'b1;
        #1;
        chk("t3_pcen_gnt",  64'(bus.pc_en), 64'd1);
        chk("t3_pc_hold",   64'(bus.pc),    64'hc00);
        tick();
        chk("t3_pcen_drop", 64'(bus.pc_en), 64'd0);
        chk("t3_pc_adv",    64'(bus.pc),    64'hc01);

        // Flush in WAIT with a late stale response
        rst = 1'b1; bus.id_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        wait_cnt(3'd2, "t4_fill");
        rsp_delay = 2;
        chk("t4_addr",    64'(bus.imem_addr), 64'hc02);
        tick();
        chk("t4_wait",    64'(bus.imem_req),  64'd0);
        chk("t4_cnt2",    64'(bus.count),     64'd2);
        bus.flush = 1'b1; redirect = 30'h1000;
        #1;
        chk("t4_pcen",    64'(bus.pc_en),     64'd1);
        tick();
        bus.flush = 1'b0;
        chk("t4_cnt0",    64'(bus.count),     64'd0);
        chk("t4_valid0",  64'(bus.id_valid),  64'd0);
        chk("t4_pc",      64'(bus.pc),        64'h1000);
        tick();
        chk("t4_drain_req", 64'(bus.imem_req), 64'd0);
        rsp_delay = 0;
        tick();
        chk("t4_drop_cnt",   64'(bus.count),    64'd0);
        chk("t4_drop_valid", 64'(bus.id_valid), 64'd0);
        tick();
        chk("t4_req",     64'(bus.imem_req),  64'd1);
        chk("t4_addr_rd", 64'(bus.imem_addr), 64'h1000);
        tick(); tick();
        chk("t4_valid",   64'(bus.id_valid),  64'd1);
        chk("t4_idpc",    64'(bus.id_pc),     64'h1000);
        chk("t4_instr",   64'(bus.id_instr),  64'h4000);
        chk("t4_cnt1",    64'(bus.count),     64'd1);

        // Same-cycle push and pop at count 2, across pointer wrap
        rst = 1'b1; bus.id_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        wait_cnt(3'd2, "t5_fill");
        exp_pc = 30'hc00;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t5_idpc_%0d", i),  64'(bus.id_pc),    64'(exp_pc));
            chk($sformatf("t5_instr_%0d", i), 64'(bus.id_instr), 64'({exp_pc, 2'b00}));
            bus.id_ready = 1'b1;
            tick();
            bus.id_ready = 1'b0;
            chk($sformatf("t5_cnt_%0d", i),   64'(bus.count),    64'd2);
            exp_pc = exp_pc + 30'd1;
        end
        chk("t5_head_end", 64'(bus.id_pc), 64'hc0a);

        // Asynchronous reset in WAIT with count 3; late response ignored
        rst = 1'b1; bus.id_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        wait_cnt(3'd3, "t6_fill");
        rsp_delay = 4;
        tick();
        chk("t6_wait",    64'(bus.imem_req), 64'd0);
        chk("t6_cnt3",    64'(bus.count),    64'd3);
        rst = 1'b1;
        #1;
        chk("t6_req",     64'(bus.imem_req), 64'd0);
        chk("t6_pcen",    64'(bus.pc_en),    64'd0);
        chk("t6_valid",   64'(bus.id_valid), 64'd0);
        chk("t6_instr",   64'(bus.id_instr), 64'd0);
        chk("t6_idpc",    64'(bus.id_pc),    64'd0);
        chk("t6_count",   64'(bus.count),    64'd0);
        bus.imem_gnt = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t6_late_cnt_%0d", i),   64'(bus.count),    64'd0);
            chk($sformatf("t6_late_valid_%0d", i), 64'(bus.id_valid), 64'd0);
        end
        rsp_delay = 0;
        bus.imem_gnt = 1'b1;
        chk("t6_req_again", 64'(bus.imem_req),  64'd1);
        chk("t6_addr",      64'(bus.imem_addr), 64'hc00);
        tick(); tick();
        chk("t6_valid_new", 64'(bus.id_valid),  64'd1);
        chk("t6_idpc_new",  64'(bus.id_pc),     64'hc00);
        chk("t6_instr_new", 64'(bus.id_instr),  64'h3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current word-address PC, issues one instruction-memory request at a time over a req/gnt + rvalid bus, and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- Presents the FIFO head to decode through a valid/ready handshake.
- Drives the PC register's EN: the PC advances only when a fetch is granted or a redirect occurs.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2.
CNT_W, 3, width of count output; must equal log2(DEPTH)+1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
pc  in  30  current PC, word address bits [31:2]
pc_en  out  1  PC register load enable
imem_req  out  1  fetch request
imem_addr  out  30  fetch word address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  instruction word
flush  in  1  redirect; discard all buffered and in-flight fetches
id_valid  out  1  FIFO head valid
id_ready  in  1  decode accepts head
id_instr  out  32  head instruction
id_pc  out  30  head word PC
count  out  CNT_W  FIFO occupancy

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset:
  - State = IDLE; FIFO pointers and count = 0.
  - imem_req = 0, pc_en = 0, id_valid = 0; id_instr = 0, id_pc = 0.
- FSM states: IDLE, REQ, WAIT, DRAIN.
  - IDLE: go to REQ when count < DEPTH and !flush.
  - REQ: imem_req = 1; imem_addr = pc (combinational pass-through). req_pc <= pc on grant.
    - gnt & !flush: go to WAIT.
    - gnt & flush: go to DRAIN.
    - !gnt & flush: go to IDLE (request withdrawn).
    - Otherwise hold REQ; pc is stable because pc_en = 0.
  - WAIT: on rvalid, write {imem_rdata, req_pc} unless flush.
    - Next state is REQ if !flush and post-update count < DEPTH; otherwise IDLE.
    - flush without rvalid: go to DRAIN.
  - DRAIN: on rvalid, discard the data and go to IDLE. flush here has no extra effect.
- pc_en = flush | (state==REQ & imem_gnt). This is combinational, so the PC loads next_PC (the sequential PC or the redirect target) in the same cycle.
- At most one outstanding request. A slot is reserved at issue time (issue only when count < DEPTH), so a response never overflows.
- FIFO:
  - Push = accepted rvalid in WAIT. Pop = id_valid & id_ready.
  - Simultaneous push and pop: count unchanged; both pointers advance.
  - Pointers wrap modulo DEPTH.
  - id_valid = (count != 0); id_instr and id_pc come from the head entry.
- flush: count and pointers clear on the next edge; id_valid = 0 from that edge onward. A pop in the same cycle as flush is ignored.
- Latency: rvalid at edge N gives id_valid = 1 after edge N. Minimum request-to-request spacing is 2 cycles (REQ, WAIT).
- id_valid is never asserted from an empty FIFO (except with the bypass feature below). No pop occurs when id_valid = 0.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty, state==WAIT, imem_rvalid = 1 and !flush:
  - id_valid = 1 combinationally; id_instr = imem_rdata; id_pc = req_pc.
  - If id_ready is also 1, the entry is consumed and not written (count stays 0).
  - Otherwise it is written normally.
- Undefined: responses always pass through the FIFO; one cycle of registered latency.

Test Plan:
- Reset, then release; bench PC model resets to 30'hc00, next_PC = pc+1, gnt = 1, rvalid 1 cycle later, rdata = {pc,2'b00}, id_ready = 1 → imem_addr sequence 0xc00, 0xc01, 0xc02; id_instr = 0x3000, 0x3004; id_pc = 0xc00, 0xc01; pc_en pulses once per grant.
- id_ready = 0, DEPTH = 4 → exactly 4 fetches (0xc00–0xc03); count = 4; state IDLE, imem_req = 0; raise id_ready → one pop, count = 3, then one new request at 0xc04.
- imem_gnt withheld 5 cycles → imem_req held with imem_addr = 0xc00 stable; pc_en = 0 throughout; grant on cycle 6 → pc_en = 1 for exactly that cycle.
- flush in WAIT with count = 2, redirect target 0x1000, rvalid arriving 2 cycles later → count = 0 next cycle; stale response dropped in DRAIN; next request addr = 0x1000; first id_pc = 0x1000.
- Same-cycle push and pop with count = 2 → count stays 2; head advances in order; pointer wrap verified over 10 consecutive instructions with no loss or reorder.
- rst asserted while in WAIT with count = 3 → all outputs return to reset values asynchronously; a late rvalid after release is ignored (state IDLE).
